mem_port_arbiter: RTL and testbench

//   Shares one single-port memory between the IF fetch path and the MEM-stage data controller.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_port_arbiter_if.sv | 40 ++++
 rtl/mem_arb_watchdog.sv | 36 +++
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_IBUSY = 2'd1,
    ARB_DBUSY = 2'd2
  } arb_state_t;

  // Wide enough for any practical bus; users slice the low DATA_W/8 bits.
  localparam logic [127:0] FETCH_BE     = '1;
  localparam logic [31:0]  TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around the arbiter.
// master: the arbiter itself. slave: the core requesters plus the memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  IReq;
  logic [ADDR_W-1:0]     IAddr;
  logic [DATA_W-1:0]     IRData;
  logic                  IAck;

  logic                  DReq;
  logic                  DWe;
  logic [ADDR_W-1:0]     DAddr;
  logic [DATA_W-1:0]     DWData;
  logic [DATA_W/8-1:0]   DByteEn;
  logic [DATA_W-1:0]     DRData;
  logic                  DAck;

  logic [ADDR_W-1:0]     MemAddr;
  logic [DATA_W-1:0]     MemWData;
  logic [DATA_W/8-1:0]   MemBE;
  logic                  MemRead;
  logic                  MemWrite;
  logic [DATA_W-1:0]     MemRData;
  logic                  MemAck;
  logic                  MemTimeout;

  modport master (
    input  IReq, IAddr, DReq, DWe, DAddr, DWData, DByteEn, MemRData, MemAck,
    output IRData, IAck, DRData, DAck, MemAddr, MemWData, MemBE, MemRead,
           MemWrite, MemTimeout
  );

  modport slave (
    output IReq, IAddr, DReq, DWe, DAddr, DWData, DByteEn, MemRData, MemAck,
    input  IRData, IAck, DRData, DAck, MemAddr, MemWData, MemBE, MemRead,
           MemWrite, MemTimeout
  );
endinterface

// File: rtl/mem_arb_watchdog.sv
// Busy-cycle counter for the arbiter; flags expiry on the last allowed busy cycle.
module mem_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic CLK,
  input  logic RST,
  input  logic start,
  input  logic busy,
  output logic expired
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The first busy cycle sees a count of 0, so expiry lands on busy cycle TIMEOUT_CYCLES.
  assign expired = busy && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Restart on every new grant, count while the transfer is outstanding.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (busy && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the data controller.
// Data wins by default; after MAX_D_STREAK back-to-back data grants with fetch
// waiting, fetch wins once. The command is registered; the ack is a combinational
// pass-through of MemAck. Optional watchdog abort: define MEM_TIMEOUT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          ADDR_W         = 32,
  parameter int          DATA_W         = 32,
  parameter int          MAX_D_STREAK   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                CLK,
  input  logic                RST,
  mem_port_arbiter_if.master  bus
);
  localparam int BE_W     = DATA_W / 8;
  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);

  arb_state_t          state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]     mem_be_q, mem_be_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;

  logic                grant_d, grant_i, streak_full;
  logic                entering_busy;
  logic                i_ack, d_ack;
  logic [DATA_W-1:0]   rdata;
  logic                expired, aborting;

  assign streak_full = (streak_q == STREAK_W'(MAX_D_STREAK));

  // Arbitration, command capture and completion handling.
  always_comb begin
    state_d       = state_q;
    streak_d      = streak_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_be_d      = mem_be_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    grant_d       = 1'b0;
    grant_i       = 1'b0;
    entering_busy = 1'b0;
    i_ack         = 1'b0;
    d_ack         = 1'b0;
    rdata         = aborting ? DATA_W'(TIMEOUT_DATA) : bus.MemRData;
    case (state_q)
      ARB_IDLE: begin
        grant_d = bus.DReq && !(bus.IReq && streak_full);
        grant_i = bus.IReq && !grant_d;
        if (grant_d) begin
          state_d       = ARB_DBUSY;
          entering_busy = 1'b1;
          mem_addr_d    = bus.DAddr;
          mem_wdata_d   = bus.DWe ? bus.DWData : '0;
          mem_be_d      = bus.DWe ? bus.DByteEn : FETCH_BE[BE_W-1:0];
          mem_read_d    = !bus.DWe;
          mem_write_d   = bus.DWe;
          // Streak only grows while fetch is actually being held off.
          if (!bus.IReq) begin
            streak_d = '0;
          end else if (!streak_full) begin
            streak_d = streak_q + 1'b1;
          end
        end else if (grant_i) begin
          state_d       = ARB_IBUSY;
          entering_busy = 1'b1;
          mem_addr_d    = bus.IAddr;
          mem_wdata_d   = '0;
          mem_be_d      = FETCH_BE[BE_W-1:0];
          mem_read_d    = 1'b1;
          mem_write_d   = 1'b0;
          streak_d      = '0;
        end
      end
      ARB_IBUSY, ARB_DBUSY: begin
        if (bus.MemAck || aborting) begin
          state_d     = ARB_IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          i_ack       = (state_q == ARB_IBUSY);
          d_ack       = (state_q == ARB_DBUSY);
        end
      end
      default: begin
        state_d     = ARB_IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  // State, streak and registered memory command.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ARB_IDLE;
      streak_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  logic timeout_q, timeout_d;

  mem_arb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .CLK     (CLK),
    .RST     (RST),
    .start   (entering_busy),
    .busy    (state_q != ARB_IDLE),
    .expired (expired)
  );

  // A real MemAck on the expiry cycle still counts as a normal completion.
  assign aborting = expired && !bus.MemAck;

  // Sticky flag: set by the first abort, cleared only by reset.
  always_comb begin
    timeout_d = timeout_q | aborting;
  end

  // Timeout flag register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign bus.MemTimeout = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^{32'(TIMEOUT_CYCLES), entering_busy};
  assign expired            = 1'b0;
  assign aborting           = expired;
  assign bus.MemTimeout     = 1'b0;
`endif

  // Acks are suppressed while reset is asserted so a dying transfer never completes.
  assign bus.IAck     = i_ack && !RST;
  assign bus.DAck     = d_ack && !RST;
  assign bus.IRData   = rdata;
  assign bus.DRData   = rdata;
  assign bus.MemAddr  = mem_addr_q;
  assign bus.MemWData = mem_wdata_q;
  assign bus.MemBE    = mem_be_q;
  assign bus.MemRead  = mem_read_q;
  assign bus.MemWrite = mem_write_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model and scoreboard.
module tb_mem_port_arbiter;
  localparam int MAX = 4;
  localparam int TO  = 8;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
  } txn_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   sb_en  = 1'b0;

  txn_t        cmd_q[$];
  txn_t        ack_q[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] mem_arr [logic [31:0]];

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(MAX), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : (a ^ 32'h5A5A_0000);
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : (a ^ 32'h5A5A_0000);
  endfunction

  int streak_m = 0;

  // Reference arbitration: decide the next transfer from the pending requests.
  task automatic predict();
    txn_t t;
    bit   take_d;
    take_d = bus.DReq && !(bus.IReq && streak_m >= MAX);
    if (take_d) begin
      t.is_d  = 1'b1;
      t.we    = bus.DWe;
      t.addr  = bus.DAddr;
      t.wdata = bus.DWData;
      t.be    = bus.DWe ? bus.DByteEn : 4'hF;
      t.rdata = 32'h0;
      streak_m = bus.IReq ? ((streak_m + 1 > MAX) ? MAX : streak_m + 1) : 0;
      if (t.we) ref_mem[t.addr] = merge(ref_rd(t.addr), t.wdata, t.be);
      else      t.rdata = ref_rd(t.addr);
    end else begin
      t.is_d  = 1'b0;
      t.we    = 1'b0;
      t.addr  = bus.IAddr;
      t.wdata = 32'h0;
      t.be    = 4'hF;
      t.rdata = ref_rd(t.addr);
      streak_m = 0;
    end
    cmd_q.push_back(t);
    ack_q.push_back(t);
  endtask

  int  ngr, nbusy;
  bit  got, i_seen, d_seen;
  int  i_issued, i_acked, d_issued, d_acked, dly;

  initial begin
    bus.IReq = 0; bus.IAddr = 0; bus.DReq = 0; bus.DWe = 0; bus.DAddr = 0;
    bus.DWData = 0; bus.DByteEn = 0; bus.MemRData = 0; bus.MemAck = 0;

    fork
      begin : monitor
        bit   prev_strobe;
        txn_t t;
        prev_strobe = 1'b0;
        forever begin
          @(negedge CLK);
          chk("strobe_excl", 32'(bus.MemRead && bus.MemWrite), 32'h0);
          if (sb_en) begin
            if ((bus.MemRead || bus.MemWrite) && !prev_strobe) begin
              if (cmd_q.size() == 0) begin
                chk("sb_cmd_unexpected", 32'(1), 32'(0));
              end else begin
                t = cmd_q.pop_front();
                chk("sb_cmd_addr", bus.MemAddr, t.addr);
                chk("sb_cmd_write", 32'(bus.MemWrite), 32'(t.we));
                chk("sb_cmd_be", 32'(bus.MemBE), 32'(t.be));
                if (t.we) chk("sb_cmd_wdata", bus.MemWData, t.wdata);
              end
            end
            if (bus.IAck || bus.DAck) begin
              if (ack_q.size() == 0) begin
                chk("sb_ack_unexpected", 32'(1), 32'(0));
              end else begin
                t = ack_q.pop_front();
                chk("sb_ack_owner", {30'h0, bus.DAck, bus.IAck}, t.is_d ? 32'h2 : 32'h1);
                if (!t.we) chk("sb_ack_rdata", t.is_d ? bus.DRData : bus.IRData, t.rdata);
              end
            end
          end
          prev_strobe = bus.MemRead || bus.MemWrite;
        end
      end
    join_none

    // Reset state
    step(); step();
    @(negedge CLK);
    chk("rst_strobes", {30'h0, bus.MemRead, bus.MemWrite}, 32'h0);
    chk("rst_acks", {30'h0, bus.IAck, bus.DAck}, 32'h0);
    chk("rst_addr", bus.MemAddr, 32'h0);
    chk("rst_be_to", {27'h0, bus.MemTimeout, bus.MemBE}, 32'h0);

    // Fetch with ack on the second busy cycle
    step(); RST = 0;
    step(); bus.IReq = 1; bus.IAddr = 32'h40;
    @(negedge CLK); chk("t1_idle_read", 32'(bus.MemRead), 32'h0);
    step();
    @(negedge CLK);
    chk("t1_read", 32'(bus.MemRead), 32'h1);
    chk("t1_addr", bus.MemAddr, 32'h40);
    chk("t1_be", 32'(bus.MemBE), 32'hF);
    chk("t1_no_early_ack", 32'(bus.IAck), 32'h0);
    step(); bus.MemAck = 1; bus.MemRData = 32'h1234_5678;
    @(negedge CLK);
    chk("t1_iack", {30'h0, bus.IAck, bus.DAck}, 32'h2);
    chk("t1_irdata", bus.IRData, 32'h1234_5678);
    step(); bus.MemAck = 0; bus.IReq = 0;
    @(negedge CLK); chk("t1_done", {30'h0, bus.MemRead, bus.IAck}, 32'h0);

    // Data write, zero-wait memory
    step(); bus.DReq = 1; bus.DWe = 1; bus.DAddr = 32'h100; bus.DWData = 32'hCAFE_F00D;
    bus.DByteEn = 4'b0011;
    step(); bus.MemAck = 1; bus.MemRData = 32'h0;
    @(negedge CLK);
    chk("t2_strobes", {30'h0, bus.MemWrite, bus.MemRead}, 32'h2);
    chk("t2_addr", bus.MemAddr, 32'h100);
    chk("t2_wdata", bus.MemWData, 32'hCAFE_F00D);
    chk("t2_be", 32'(bus.MemBE), 32'h3);
    chk("t2_dack", 32'(bus.DAck), 32'h1);
    step(); bus.MemAck = 0; bus.DReq = 0; bus.DWe = 0;
    @(negedge CLK); chk("t2_bubble", {30'h0, bus.MemWrite, bus.DAck}, 32'h0);

    // Both requests held: D,D,D,D,I pattern
    step(); bus.IReq = 1; bus.IAddr = 32'h200; bus.DReq = 1; bus.DAddr = 32'h300;
    ngr = 0;
    for (int c = 0; c < 60 && ngr < 10; c++) begin
      step();
      bus.MemAck = bus.MemRead || bus.MemWrite;
      @(negedge CLK);
      if (bus.MemAck) begin
        chk("t3_grant", bus.MemAddr, (ngr % 5 == 4) ? 32'h200 : 32'h300);
        chk("t3_iack", 32'(bus.IAck), (ngr % 5 == 4) ? 32'h1 : 32'h0);
        ngr++;
      end
    end
    chk("t3_count", 32'(ngr), 32'd10);
    step(); bus.IReq = 0; bus.DReq = 0; bus.MemAck = 0;

    // Reset in DBUSY, late MemAck ignored
    step(); bus.DReq = 1; bus.DWe = 0; bus.DAddr = 32'h80;
    step();
    @(negedge CLK); chk("t4_busy", 32'(bus.MemRead), 32'h1);
    step(); RST = 1; bus.DReq = 0;
    step(); RST = 0; bus.MemAck = 1; bus.MemRData = 32'hBAD0_BAD0;
    @(negedge CLK);
    chk("t4_strobes", {30'h0, bus.MemRead, bus.MemWrite}, 32'h0);
    chk("t4_acks", {30'h0, bus.IAck, bus.DAck}, 32'h0);
    chk("t4_addr_be", bus.MemAddr | 32'(bus.MemBE), 32'h0);
    step(); bus.MemAck = 0; bus.IReq = 1; bus.IAddr = 32'h44;
    step(); bus.MemAck = 1; bus.MemRData = 32'hA5A5_0044;
    @(negedge CLK);
    chk("t4_after_addr", bus.MemAddr, 32'h44);
    chk("t4_after_iack", 32'(bus.IAck), 32'h1);
    chk("t4_after_rdata", bus.IRData, 32'hA5A5_0044);
    step(); bus.IReq = 0; bus.MemAck = 0;

`ifdef MEM_TIMEOUT_EN
    // Watchdog abort after TO busy cycles
    step(); bus.IReq = 1; bus.IAddr = 32'h48;
    nbusy = 0; got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      step();
      @(negedge CLK);
      if (bus.MemRead) nbusy++;
      if (bus.IAck) begin
        got = 1;
        chk("t5_cycles", 32'(nbusy), 32'(TO));
        chk("t5_rdata", bus.IRData, 32'hDEAD_BEEF);
      end
    end
    chk("t5_got_ack", 32'(got), 32'h1);
    step(); bus.IReq = 0;
    @(negedge CLK);
    chk("t5_flag", 32'(bus.MemTimeout), 32'h1);
    chk("t5_strobe_drop", 32'(bus.MemRead), 32'h0);
    repeat (3) step();
    @(negedge CLK); chk("t5_sticky", 32'(bus.MemTimeout), 32'h1);
    step(); RST = 1;
    step(); RST = 0;
    @(negedge CLK); chk("t5_cleared", 32'(bus.MemTimeout), 32'h0);
`else
    @(negedge CLK); chk("timeout_tied", 32'(bus.MemTimeout), 32'h0);
`endif

    // Randomized traffic against the reference model
    step(); RST = 1;
    step(); RST = 0;
    streak_m = 0; sb_en = 1;
    i_issued = 0; i_acked = 0; d_issued = 0; d_acked = 0;
    dly = $urandom_range(0, 5);
    got = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge CLK);
      i_seen = bus.IAck; d_seen = bus.DAck;
      step();
      if (i_seen) begin bus.IReq = 0; i_acked++; end
      if (d_seen) begin bus.DReq = 0; d_acked++; end
      if (c < 2500) begin
        if (!bus.IReq && $urandom_range(0, 2) == 0) begin
          bus.IReq  = 1;
          bus.IAddr = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
          i_issued++;
        end
        if (!bus.DReq && $urandom_range(0, 2) == 0) begin
          bus.DReq    = 1;
          bus.DWe     = 1'($urandom_range(0, 1));
          bus.DAddr   = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
          bus.DWData  = $urandom;
          bus.DByteEn = 4'($urandom_range(0, 15));
          d_issued++;
        end
      end
      if (bus.MemAck) begin
        bus.MemAck = 0;
      end else if (bus.MemRead || bus.MemWrite) begin
        if (dly == 0) begin
          bus.MemAck = 1;
          if (bus.MemWrite) mem_arr[bus.MemAddr] = merge(mem_rd(bus.MemAddr), bus.MemWData, bus.MemBE);
          else              bus.MemRData = mem_rd(bus.MemAddr);
          dly = $urandom_range(0, 5);
        end else begin
          dly--;
        end
      end
      if (!bus.MemRead && !bus.MemWrite && (bus.IReq || bus.DReq)) predict();
      if (c >= 2500 && !bus.IReq && !bus.DReq && !bus.MemRead && !bus.MemWrite &&
          cmd_q.size() == 0 && ack_q.size() == 0) begin
        got = 1;
        break;
      end
    end
    chk("t6_drained", 32'(got), 32'h1);
    chk("t6_i_acks", 32'(i_acked), 32'(i_issued));
    chk("t6_d_acks", 32'(d_acked), 32'(d_issued));
    chk("t6_cmd_q_empty", 32'(cmd_q.size()), 32'h0);
    chk("t6_ack_q_empty", 32'(ack_q.size()), 32'h0);
    sb_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
